// File: rtl/axi_slv_rd_mem_pkg.sv
// axi_slv_rd_mem shared types and constants.
// FSM encoding, AXI widths, log2 helper.
package axi_slv_rd_mem_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  // Holds RD_LATENCY-1 for latencies 1..4.
  localparam int LAT_CNT_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } rd_state_e;

  function automatic int log2_f(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/axi_slv_rd_mem_lat_cnt.sv
// axi_slv_rd_lat_cnt: loadable down-counter
// with zero flag, used for the SRAM wait.
module axi_slv_rd_lat_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  // Load wins; decrement saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/axi_slv_rd_mem.sv
// axi_slv_rd_mem: single-beat SRAM read backend.
// Option AXI_SLV_RD_MEM_OOR_EN: range check/err.
module axi_slv_rd_mem
  import axi_slv_rd_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = AXI_ADDR_W,
  parameter int DATA_WIDTH = AXI_DATA_W,
  parameter int MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int RD_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rd_req_en,
  input  logic [ADDR_WIDTH-1:0]        rd_base_addr,
  output logic                         rd_req_rdy,
  output logic                         rd_result_en,
  output logic [DATA_WIDTH-1:0]        rd_result_data,
  input  logic                         rd_result_rdy,
  output logic                         rd_result_err,
  output logic                         mem_ce,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]        mem_rdata
);

  localparam int AW    = log2_f(MEM_DEPTH);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BO    = log2_f(BYTES);

  rd_state_e state, state_nxt;

  logic [ADDR_WIDTH-1:0] offset;
  logic [AW-1:0]         word_idx;
  logic                  unused_off;
  logic                  req_oor;
  logic                  accept;
  logic                  cnt_zero;
  logic [LAT_CNT_W-1:0]  cnt;

  assign offset   = rd_base_addr - BASE_ADDR;
  assign word_idx = offset[BO +: AW];
  assign unused_off = ^{offset[BO-1:0],
                        offset[ADDR_WIDTH-1:BO+AW]};

`ifdef AXI_SLV_RD_MEM_OOR_EN
  localparam logic [ADDR_WIDTH:0] LO =
    {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] HI =
    LO + (ADDR_WIDTH+1)'(MEM_DEPTH * BYTES);

  assign req_oor = ({1'b0, rd_base_addr} < LO) ||
                   ({1'b0, rd_base_addr} >= HI);
`else
  assign req_oor = 1'b0;
`endif

  assign accept       = (state == ST_IDLE) && rd_req_en;
  assign rd_req_rdy   = (state == ST_IDLE);
  assign rd_result_en = (state == ST_RESP);
  assign mem_ce       = (state == ST_RD);

  axi_slv_rd_lat_cnt #(
    .W (LAT_CNT_W)
  ) u_lat_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == ST_RD),
    .load_val (LAT_CNT_W'(RD_LATENCY - 1)),
    .dec      (state == ST_WAIT),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (rd_req_en) begin
          state_nxt = req_oor ? ST_RESP : ST_RD;
        end
      end
      ST_RD: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (cnt_zero) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (rd_result_rdy) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Address latch on accept, data capture at end of wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr       <= '0;
      rd_result_data <= '0;
    end else if (accept) begin
      mem_addr <= word_idx;
      if (req_oor) rd_result_data <= '0;
    end else if ((state == ST_WAIT) && cnt_zero) begin
      rd_result_data <= mem_rdata;
    end
  end

`ifdef AXI_SLV_RD_MEM_OOR_EN
  logic err_q;

  // Error flag follows the accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= req_oor;
    end
  end

  assign rd_result_err = err_q;
`else
  assign rd_result_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_slv_rd_mem.sv
// Testbench for axi_slv_rd_mem.
// Scoreboard plus directed timing checks.
module tb_axi_slv_rd_mem;

  localparam int LAT = 3;
  localparam int DEPTH = 16;
`ifdef AXI_SLV_RD_MEM_OOR_EN
  localparam logic [31:0] BASE = 32'h1000;
`else
  localparam logic [31:0] BASE = 32'h100;
`endif

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_req_en;
  logic [31:0] rd_base_addr;
  logic        rd_req_rdy;
  logic        rd_result_en;
  logic [31:0] rd_result_data;
  logic        rd_result_rdy;
  logic        rd_result_err;
  logic        mem_ce;
  logic [3:0]  mem_addr;
  logic [31:0] mem_rdata;

  logic [31:0] mem [DEPTH];
  logic [31:0] pipe [LAT];
  exp_t        q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc [4];

  axi_slv_rd_mem #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MEM_DEPTH  (DEPTH),
    .BASE_ADDR  (BASE),
    .RD_LATENCY (LAT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rd_req_en      (rd_req_en),
    .rd_base_addr   (rd_base_addr),
    .rd_req_rdy     (rd_req_rdy),
    .rd_result_en   (rd_result_en),
    .rd_result_data (rd_result_data),
    .rd_result_rdy  (rd_result_rdy),
    .rd_result_err  (rd_result_err),
    .mem_ce         (mem_ce),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: data valid LAT cycles after mem_ce,
  // garbage otherwise.
  always @(posedge clk) begin
    pipe[0] <= mem_ce ? mem[mem_addr] : $urandom;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, got, exp);
    end
  endtask

  function automatic logic [3:0] widx(
    input logic [31:0] a);
    logic [31:0] o;
    o = (a - BASE) >> 2;
    return o[3:0];
  endfunction

  function automatic logic is_oor(input logic [31:0] a);
`ifdef AXI_SLV_RD_MEM_OOR_EN
    return (a < BASE) ||
           ({1'b0, a} >= {1'b0, BASE} + 33'(DEPTH * 4));
`else
    return (a == 32'h0) && (a != 32'h0);
`endif
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] a);
    exp_t e;
    e.e = is_oor(a);
    e.d = e.e ? 32'h0 : mem[widx(a)];
    return e;
  endfunction

  // Scoreboard: pop on every result handshake.
  always @(negedge clk) begin
    if (rst_n && rd_result_en && rd_result_rdy) begin
      checks++;
      assert (q.size() > 0) else begin
        errors++;
        $error("FAIL sb_empty: got result %0h expected none",
               rd_result_data);
      end
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        chk("sb_data", rd_result_data, mon_e.d);
        chk("sb_err", rd_result_err, mon_e.e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy();
    int n;
    n = 0;
    while (!rd_req_rdy && n < 40) begin
      step();
      n++;
    end
    chk("wait_rdy", rd_req_rdy, 1);
  endtask

  task automatic one_req(input logic [31:0] a);
    wait_rdy();
    rd_base_addr = a;
    rd_req_en = 1'b1;
    q.push_back(mk_exp(a));
    step();
    rd_req_en = 1'b0;
    if (is_oor(a)) begin
      chk("oor_ce", mem_ce, 0);
      chk("oor_en", rd_result_en, 1);
      chk("oor_data", rd_result_data, 0);
      chk("oor_err", rd_result_err, 1);
    end else begin
      chk("req_ce", mem_ce, 1);
      chk("req_addr", mem_addr, widx(a));
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++)
      mem[i] = 32'h5A00_0011 + i * 32'h0001_0203;
    mem[5] = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    rd_req_en = 1'b0;
    rd_base_addr = '0;
    rd_result_rdy = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    chk("rst_rdy", rd_req_rdy, 1);
    chk("rst_en", rd_result_en, 0);
    chk("rst_data", rd_result_data, 0);
    chk("rst_err", rd_result_err, 0);
    chk("rst_ce", mem_ce, 0);
    chk("rst_addr", mem_addr, 0);

    // Single request, full timing.
    rd_base_addr = BASE + 32'h14;
    rd_req_en = 1'b1;
    q.push_back(mk_exp(BASE + 32'h14));
    step();
    rd_req_en = 1'b0;
    chk("t1_ce", mem_ce, 1);
    chk("t1_addr", mem_addr, 5);
    chk("t1_rdy_lo", rd_req_rdy, 0);
    for (int c = 2; c <= LAT + 1; c++) begin
      step();
      chk("t1_en_early", rd_result_en, 0);
      chk("t1_ce_once", mem_ce, 0);
      chk("t1_rdy_busy", rd_req_rdy, 0);
    end
    step();
    chk("t1_en", rd_result_en, 1);
    chk("t1_data", rd_result_data, 32'hDEAD_BEEF);
    chk("t1_rdy_resp", rd_req_rdy, 0);
    step();
    chk("t1_en_pulse", rd_result_en, 0);
    chk("t1_rdy_back", rd_req_rdy, 1);

    // Stalled consumer, ignored request in RESP.
    rd_result_rdy = 1'b0;
    rd_base_addr = BASE + 32'h1C;
    rd_req_en = 1'b1;
    q.push_back(mk_exp(BASE + 32'h1C));
    step();
    rd_req_en = 1'b0;
    repeat (LAT + 1) step();
    rd_base_addr = BASE + 32'h24;
    rd_req_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("st_en", rd_result_en, 1);
      chk("st_data", rd_result_data, mem[7]);
      chk("st_rdy", rd_req_rdy, 0);
      chk("st_ce", mem_ce, 0);
      step();
    end
    rd_result_rdy = 1'b1;
    chk("st_sim_rdy", rd_req_rdy, 0);
    step();
    chk("st_idle_rdy", rd_req_rdy, 1);
    chk("st_en_off", rd_result_en, 0);
    chk("st_hold", rd_result_data, mem[7]);
    q.push_back(mk_exp(BASE + 32'h24));
    step();
    rd_req_en = 1'b0;
    chk("st_ce2", mem_ce, 1);
    chk("st_addr2", mem_addr, 9);

    // Back-to-back with rdy tied high.
    for (int k = 0; k < 4; k++) begin
      wait_rdy();
      rd_base_addr = BASE + 32'(4 * k);
      rd_req_en = 1'b1;
      q.push_back(mk_exp(BASE + 32'(4 * k)));
      acc[k] = cyc;
      step();
      rd_req_en = 1'b0;
      chk("b2b_addr", mem_addr, 4'(k));
    end
    for (int k = 1; k < 4; k++)
      chk("b2b_gap", 64'(acc[k] - acc[k-1]), LAT + 3);

    // Wrap / range boundaries.
    one_req(BASE + 32'h48);
    one_req(BASE - 32'h4);
    one_req(BASE + 32'h3C);
    one_req(BASE + 32'h40);
    wait_rdy();

    // Reset while waiting on the SRAM.
    rd_base_addr = BASE + 32'h10;
    rd_req_en = 1'b1;
    q.push_back(mk_exp(BASE + 32'h10));
    step();
    rd_req_en = 1'b0;
    step();
    chk("rs_pre_data", rd_result_data != 0, 1);
    rst_n = 1'b0;
    #1;
    chk("rs_en", rd_result_en, 0);
    chk("rs_data", rd_result_data, 0);
    chk("rs_addr", mem_addr, 0);
    chk("rs_ce", mem_ce, 0);
    chk("rs_rdy", rd_req_rdy, 1);
    q.delete();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rs_no_res", rd_result_en, 0);
    end
    one_req(BASE + 32'h24);
    wait_rdy();
    step();
    chk("sb_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_slv_rd_mem.md
Name: axi_slv_rd_mem

Overview:
- Read backend that sits directly downstream of the AXI slave read controller.
- Consumes single-beat read requests (rd_req_en / rd_base_addr) and turns each into one synchronous-SRAM access with configurable read latency.
- Returns the word to the controller on rd_result_en / rd_result_data.
- One request outstanding at a time; a valid/ready pair on each side provides flow control.

Parameters:
ADDR_WIDTH, 32, byte address width of rd_base_addr
DATA_WIDTH, 32, word width; must be 32 or 64
MEM_DEPTH, 1024, SRAM words; power of two
BASE_ADDR, 32'h0, byte address mapped to SRAM word 0
RD_LATENCY, 1, SRAM cycles from mem_ce to valid mem_rdata; legal range 1..4

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rd_req_en  in  1  read request valid
rd_base_addr  in  ADDR_WIDTH  byte address of requested word
rd_req_rdy  out  1  request accepted when rd_req_en && rd_req_rdy
rd_result_en  out  1  result valid; held until rd_result_rdy
rd_result_data  out  DATA_WIDTH  read word
rd_result_rdy  in  1  consumer accepts result
rd_result_err  out  1  out-of-range flag (only with option, else tied 0)
mem_ce  out  1  SRAM read enable, one-cycle pulse
mem_addr  out  log2(MEM_DEPTH)  SRAM word address
mem_rdata  in  DATA_WIDTH  SRAM read data

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. Reset values: state=IDLE, rd_req_rdy=1 (combinational from IDLE), rd_result_en=0, rd_result_data=0, rd_result_err=0, mem_ce=0, mem_addr=0, latency counter=0.
- Word index: (rd_base_addr - BASE_ADDR) >> log2(DATA_WIDTH/8). The low byte-offset bits are ignored. The index is truncated to log2(MEM_DEPTH) bits when the option is off.
- FSM states: IDLE, RD, WAIT, RESP.
  - IDLE: rd_req_rdy=1. On rd_req_en, register mem_addr, set mem_ce=1, go to RD.
  - RD: mem_ce=1 for exactly this cycle. Load counter with RD_LATENCY-1, go to WAIT.
  - WAIT: counter decrements each cycle. When the counter is 0, capture mem_rdata into rd_result_data and go to RESP. For RD_LATENCY=1 this capture happens in the first WAIT cycle.
  - RESP: rd_result_en=1; rd_result_data and rd_result_err are stable. When rd_result_rdy is high, go to IDLE.
- Timing: request accepted in cycle 0 → mem_ce in cycle 1 → rd_result_en first high in cycle RD_LATENCY+2.
- Back-to-back: rd_req_rdy is high again in the cycle after the result handshake. Throughput is one word per RD_LATENCY+3 cycles with rd_result_rdy tied high. With rd_result_rdy tied high, rd_result_en is a one-cycle pulse.
- rd_req_en is sampled only in IDLE; requests while rd_req_rdy=0 are ignored, not queued.
- Simultaneous events: a result handshake and a new rd_req_en in the same cycle → the request is not accepted that cycle (state is RESP). It is accepted the next cycle if still asserted.
- rd_result_data holds its last value after a handshake until the next capture.
- Reset mid-operation: everything returns to reset values immediately. In-flight SRAM data is discarded and no result is produced.

Optional Feature:
- Macro AXI_SLV_RD_MEM_OOR_EN.
- Defined: a request whose address is below BASE_ADDR or at/above BASE_ADDR + MEM_DEPTH*DATA_WIDTH/8 does not pulse mem_ce. The FSM goes IDLE→RESP directly next cycle with rd_result_data=0 and rd_result_err=1. In-range requests have rd_result_err=0.
- Undefined: no range check; the address wraps modulo the SRAM size, and rd_result_err is constant 0.

Decomposition:
- Shared defines header holds: FSM state encoding (2-bit), AXI width macros, and a log2 helper constant for MEM_DEPTH and byte-offset bits.
- One natural sub-module: axi_slv_rd_lat_cnt, a loadable down-counter with a zero flag, reused for the SRAM latency wait.

Test Plan:
- RD_LATENCY=1, BASE_ADDR=0, mem[5]=32'hDEAD_BEEF; req addr 0x14 with rd_result_rdy=1 → mem_ce cycle 1 with mem_addr=5; rd_result_en pulse cycle 3 with data DEADBEEF.
- RD_LATENCY=3; req addr 0x0 → rd_result_en first high cycle 5; rd_req_rdy low cycles 1–5, high cycle 6.
- rd_result_rdy held low 4 cycles in RESP → rd_result_en and data stay stable 4 cycles; second rd_req_en during RESP is ignored; mem_ce not pulsed.
- Four back-to-back reqs at 0x0,0x4,0x8,0xC, rdy tied 1 → four results in order, spaced RD_LATENCY+3 cycles.
- rst_n asserted in WAIT → outputs zero same cycle; after release no rd_result_en appears; next req works normally.
- OOR_EN defined, BASE_ADDR=0x1000, MEM_DEPTH=16; req 0x1040 → no mem_ce, rd_result_en cycle 1, data 0, err 1; req 0x103C → err 0.
